// File: rtl/chip_shift_engine.sv
// Serial shift engine behind the control FSM's WRITE state: pops configuration bytes
// from fifo1, shifts them MSB-first on sdo/sclk and pushes the byte returned on sdi into fifo2.
module chip_shift_engine #(
    parameter int CLK_DIV     = 50,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic        clk_100,
    input  logic        Reset,
    input  logic        run,
    input  logic        fifo1_empty,
    input  logic [7:0]  fifo1_dout,
    input  logic        fifo1_valid,
    output logic        fifo1_rd_en,
    input  logic        fifo2_full,
    output logic [7:0]  fifo2_din,
    output logic        fifo2_wr_en,
    output logic        sclk,
    output logic        sdo,
    input  logic        sdi,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [15:0] byte_count
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ACK,
        SHIFT,
        STORE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [ACK_W-1:0] ack_cnt;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic [15:0]      byte_count_q;
    logic             ack_err_q;
    logic             ack_timeout;
    logic             rd_strobe;
    logic             wr_strobe;
    logic             done_pulse;

    always_ff @(posedge clk_100) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        rd_strobe   = 1'b0;
        wr_strobe   = 1'b0;
        done_pulse  = 1'b0;
        ack_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (run && !fifo1_empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                rd_strobe  = 1'b1;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (fifo1_valid) begin
                    state_next = SHIFT;
                end else if (ack_cnt == ACK_LAST) begin
                    ack_timeout = 1'b1;
                    done_pulse  = 1'b1;
                    state_next  = IDLE;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST && bit_cnt == 3'd0) begin
                    state_next = STORE;
                end
            end
            STORE: begin
                if (!fifo2_full) begin
                    wr_strobe = 1'b1;
                    if (run && !fifo1_empty) begin
                        state_next = FETCH;
                    end else begin
                        done_pulse = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx is not shifted after the last bit so sdo keeps bit 0 while STORE waits on fifo2
    always_ff @(posedge clk_100) begin
        if (Reset) begin
            div_cnt      <= '0;
            bit_cnt      <= 3'd0;
            ack_cnt      <= '0;
            tx_shift     <= 8'h00;
            rx_shift     <= 8'h00;
            byte_count_q <= 16'h0000;
            ack_err_q    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (fifo1_valid) begin
                        tx_shift <= fifo1_dout;
                        rx_shift <= 8'h00;
                        bit_cnt  <= 3'd7;
                        div_cnt  <= '0;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_HALF) begin
                        rx_shift <= {rx_shift[6:0], sdi};
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt != 3'd0) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt - 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: ;
            endcase
            if (ack_timeout) begin
                ack_err_q <= 1'b1;
            end
            if (wr_strobe) begin
                byte_count_q <= byte_count_q + 16'd1;
            end
        end
    end

    assign fifo1_rd_en = rd_strobe;
    assign fifo2_wr_en = wr_strobe;
    assign fifo2_din   = (state == STORE) ? rx_shift : 8'h00;
    assign sclk        = (state == SHIFT) && (div_cnt >= DIV_HALF);
    assign sdo         = (state == SHIFT || state == STORE) ? tx_shift[7] : 1'b0;
    assign busy        = (state != IDLE);
    assign done        = done_pulse;
    assign ack_err     = ack_err_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_chip_shift_engine.sv
// Bench for chip_shift_engine: bench-side fifo1/fifo2 models, a per-cycle byte/bit scoreboard
// and directed scenarios with hand-computed cycle positions (CLK_DIV=4, 67 cycles per byte).
module tb_chip_shift_engine;

    localparam int CLK_DIV     = 4;
    localparam int ACK_TIMEOUT = 4;

    logic        clk_100 = 1'b0;
    logic        Reset;
    logic        run;
    logic        fifo1_empty = 1'b1;
    logic [7:0]  fifo1_dout  = 8'h00;
    logic        fifo1_valid = 1'b0;
    logic        fifo1_rd_en;
    logic        fifo2_full;
    logic [7:0]  fifo2_din;
    logic        fifo2_wr_en;
    logic        sclk;
    logic        sdo;
    logic        sdi;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic [15:0] byte_count;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic [7:0] fifo1_q[$];
    bit   ack_enable = 1'b1;
    bit   sdi_tie    = 1'b0;

    logic       tr_sdo[0:255];
    logic       tr_sclk[0:255];
    logic       tr_rd[0:255];
    logic       tr_wr[0:255];
    logic       tr_done[0:255];
    logic       tr_busy[0:255];
    logic       tr_ackerr[0:255];
    logic [7:0] tr_din[0:255];
    logic [15:0] tr_count[0:255];

    always #5 clk_100 = ~clk_100;

    assign sdi = sdi_tie ? 1'b1 : sdo;

    chip_shift_engine #(
        .CLK_DIV     (CLK_DIV),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_100     (clk_100),
        .Reset       (Reset),
        .run         (run),
        .fifo1_empty (fifo1_empty),
        .fifo1_dout  (fifo1_dout),
        .fifo1_valid (fifo1_valid),
        .fifo1_rd_en (fifo1_rd_en),
        .fifo2_full  (fifo2_full),
        .fifo2_din   (fifo2_din),
        .fifo2_wr_en (fifo2_wr_en),
        .sclk        (sclk),
        .sdo         (sdo),
        .sdi         (sdi),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .byte_count  (byte_count)
    );

    // fifo1 answers a read strobe with data valid the following cycle
    always @(posedge clk_100) begin
        if (fifo1_rd_en && fifo1_q.size() > 0) begin
            fifo1_dout  <= fifo1_q.pop_front();
            fifo1_valid <= ack_enable;
        end else begin
            fifo1_valid <= 1'b0;
        end
        fifo1_empty <= (fifo1_q.size() == 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic run_v, input logic reset_v, input logic full_v);
        run        = run_v;
        Reset      = reset_v;
        fifo2_full = full_v;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(1);
    endtask

    task automatic recordTrace(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            @(negedge clk_100);
            tr_sdo[k]    = sdo;
            tr_sclk[k]   = sclk;
            tr_rd[k]     = fifo1_rd_en;
            tr_wr[k]     = fifo2_wr_en;
            tr_done[k]   = done;
            tr_busy[k]   = busy;
            tr_ackerr[k] = ack_err;
            tr_din[k]    = fifo2_din;
            tr_count[k]  = byte_count;
        end
        @(posedge clk_100);
        #1;
    endtask

    function automatic int countHigh(input int sel, input int first, input int last);
        int n = 0;
        for (int k = first; k <= last; k++) begin
            if (sel == 0 && tr_wr[k] === 1'b1) n++;
            if (sel == 1 && tr_done[k] === 1'b1) n++;
            if (sel == 2 && tr_rd[k] === 1'b1) n++;
        end
        return n;
    endfunction

    // Scoreboard: expected return bytes, per-bit sdo, sclk high width, ack timeout, byte count
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_byte;
    logic [7:0]  cur_tx        = 8'h00;
    logic [15:0] model_count   = 16'h0000;
    logic        model_ack_err = 1'b0;
    bit          rst_seen = 1'b0, rd_pending = 1'b0, set_ack_err;
    bit          prev_rd = 1'b0, prev_wr = 1'b0, prev_sclk = 1'b0;
    int          ack_age = 0, bit_idx = 7, bits_seen = 0, hi_len = 0;

    always @(negedge clk_100) begin
        set_ack_err = 1'b0;
        if (rst_seen) begin
            checkOutput("after_reset_outputs", {25'd0, sclk, sdo, busy, done, fifo1_rd_en, fifo2_wr_en, ack_err}, 32'd0);
        end
        checkOutput("byte_count", byte_count, model_count);
        checkOutput("ack_err", ack_err, model_ack_err);
        if (!busy) checkOutput("idle_sclk_sdo", {sclk, sdo}, 0);
        if (prev_rd) checkOutput("rd_en_single_cycle", fifo1_rd_en, 0);
        if (prev_wr) checkOutput("wr_en_single_cycle", fifo2_wr_en, 0);
        if (fifo2_full) checkOutput("no_write_while_full", fifo2_wr_en, 0);
        if (fifo1_rd_en) begin
            rd_pending = 1'b1;
            ack_age    = 0;
        end else if (rd_pending) begin
            ack_age++;
            if (fifo1_valid) begin
                rd_pending = 1'b0;
                exp_q.push_back(sdi_tie ? 8'hFF : fifo1_dout);
                cur_tx    = fifo1_dout;
                bit_idx   = 7;
                bits_seen = 0;
            end else if (ack_age == ACK_TIMEOUT) begin
                checkOutput("timeout_done", done, 1);
                rd_pending  = 1'b0;
                set_ack_err = 1'b1;
            end
        end
        if (sclk && !prev_sclk) begin
            if (bits_seen < 8) checkOutput("sdo_at_sclk_rise", sdo, cur_tx[bit_idx]);
            bits_seen++;
            bit_idx--;
        end
        if (sclk) begin
            hi_len++;
        end else if (hi_len != 0) begin
            checkOutput("sclk_high_width", hi_len, CLK_DIV);
            hi_len = 0;
        end
        if (fifo2_wr_en && !fifo2_full) begin
            checkOutput("write_has_expected_byte", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_byte = exp_q.pop_front();
                checkOutput("fifo2_din", fifo2_din, exp_byte);
            end
            checkOutput("sclk_rises_per_byte", bits_seen, 8);
            model_count++;
        end
        if (set_ack_err) model_ack_err = 1'b1;
        prev_rd   = fifo1_rd_en;
        prev_wr   = fifo2_wr_en;
        prev_sclk = sclk;
        rst_seen  = Reset;
        if (Reset) begin
            exp_q.delete();
            model_count   = 16'h0000;
            model_ack_err = 1'b0;
            rd_pending    = 1'b0;
            bits_seen     = 0;
            hi_len        = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: run did not complete, %0d tests run", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    // Per byte: cycle 0 run seen, 1 FETCH, 2 WAIT_ACK, 3..66 SHIFT, 67 STORE
    initial begin
        int sdo_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        @(negedge clk_100);
        checkOutput("reset_state", {sclk, sdo, busy, done, fifo1_rd_en, fifo2_wr_en, ack_err}, 0);
        checkOutput("reset_byte_count", byte_count, 0);
        @(posedge clk_100);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(2);

        $display("[TB] single byte 0xA5 with loopback");
        fifo1_q.push_back(8'hA5);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        recordTrace(0, 72);
        checkOutput("a5_rd_cycle", tr_rd[1], 1);
        for (int k = 3; k <= 66; k++) begin
            checkOutput("a5_sdo_bit", tr_sdo[k], sdo_bits[(k - 3) / 8]);
            checkOutput("a5_sclk_phase", tr_sclk[k], ((k - 3) % 8) >= 4);
        end
        checkOutput("a5_write_cycle", tr_wr[67], 1);
        checkOutput("a5_write_data", tr_din[67], 8'hA5);
        checkOutput("a5_write_count", countHigh(0, 0, 71), 1);
        checkOutput("a5_done_cycle", tr_done[67], 1);
        checkOutput("a5_done_count", countHigh(1, 0, 71), 1);
        checkOutput("a5_byte_count", tr_count[69], 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        doReset();

        $display("[TB] three bytes with sdi tied high");
        sdi_tie = 1'b1;
        fifo1_q.push_back(8'h00);
        fifo1_q.push_back(8'hFF);
        fifo1_q.push_back(8'h3C);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        recordTrace(0, 206);
        for (int b = 0; b < 3; b++) begin
            checkOutput("burst_rd_cycle", tr_rd[1 + 67 * b], 1);
            checkOutput("burst_write_cycle", tr_wr[67 + 67 * b], 1);
            checkOutput("burst_write_data", tr_din[67 + 67 * b], 8'hFF);
        end
        checkOutput("burst_write_count", countHigh(0, 0, 205), 3);
        checkOutput("burst_done_count", countHigh(1, 0, 205), 1);
        checkOutput("burst_done_cycle", tr_done[201], 1);
        for (int k = 1; k <= 201; k++) checkOutput("burst_no_idle", tr_busy[k], 1);
        checkOutput("burst_idle_after", tr_busy[202], 0);
        checkOutput("burst_byte_count", tr_count[204], 3);
        sdi_tie = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        doReset();

        $display("[TB] run falls during bit 3 of first of two bytes");
        fifo1_q.push_back(8'h5A);
        fifo1_q.push_back(8'h33);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        recordTrace(0, 37);
        applyStimulus(1'b0, 1'b0, 1'b0);
        recordTrace(37, 40);
        checkOutput("rundrop_write_count", countHigh(0, 0, 76), 1);
        checkOutput("rundrop_write_data", tr_din[67], 8'h5A);
        checkOutput("rundrop_done_cycle", tr_done[67], 1);
        checkOutput("rundrop_read_count", countHigh(2, 0, 76), 1);
        checkOutput("rundrop_idle", tr_busy[70], 0);
        checkOutput("rundrop_fifo1_left", fifo1_q.size(), 1);
        if (fifo1_q.size() == 1) checkOutput("rundrop_fifo1_byte", fifo1_q[0], 8'h33);
        fifo1_q.delete();
        doReset();

        $display("[TB] fifo2 full stall on byte 0x81");
        fifo1_q.push_back(8'h81);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        recordTrace(0, 87);
        applyStimulus(1'b1, 1'b0, 1'b0);
        recordTrace(87, 8);
        for (int k = 67; k <= 86; k++) begin
            checkOutput("stall_sclk_low", tr_sclk[k], 0);
            checkOutput("stall_no_write", tr_wr[k], 0);
            checkOutput("stall_busy", tr_busy[k], 1);
            checkOutput("stall_sdo_held", tr_sdo[k], 1);
        end
        checkOutput("stall_write_cycle", tr_wr[87], 1);
        checkOutput("stall_write_data", tr_din[87], 8'h81);
        checkOutput("stall_done_cycle", tr_done[87], 1);
        checkOutput("stall_byte_count", tr_count[89], 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(2);

        $display("[TB] read acknowledge never arrives");
        ack_enable = 1'b0;
        fifo1_q.push_back(8'h77);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        recordTrace(0, 10);
        checkOutput("noack_rd_cycle", tr_rd[1], 1);
        checkOutput("noack_done_cycle", tr_done[5], 1);
        checkOutput("noack_done_count", countHigh(1, 0, 9), 1);
        checkOutput("noack_ack_err", tr_ackerr[8], 1);
        checkOutput("noack_idle", tr_busy[8], 0);
        checkOutput("noack_count_kept", tr_count[8], 1);
        checkOutput("noack_read_count", countHigh(2, 0, 9), 1);
        ack_enable = 1'b1;
        doReset();
        @(negedge clk_100);
        checkOutput("reset_clears_ack_err", ack_err, 0);
        checkOutput("reset_clears_byte_count", byte_count, 0);
        @(posedge clk_100);
        #1;

        $display("[TB] reset during SHIFT high phase");
        fifo1_q.push_back(8'hC3);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        recordTrace(0, 16);
        applyStimulus(1'b1, 1'b1, 1'b0);
        recordTrace(16, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        recordTrace(17, 100);
        checkOutput("midshift_sclk_before", tr_sclk[16], 1);
        checkOutput("midshift_sdo_before", tr_sdo[16], 1);
        checkOutput("midshift_sclk_after", tr_sclk[17], 0);
        checkOutput("midshift_sdo_after", tr_sdo[17], 0);
        checkOutput("midshift_busy_after", tr_busy[17], 0);
        checkOutput("midshift_no_write", countHigh(0, 0, 116), 0);
        checkOutput("midshift_no_done", countHigh(1, 0, 116), 0);
        checkOutput("midshift_byte_count", tr_count[116], 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/chip_shift_engine.md
# chip_shift_engine

Serial datapath behind the control FSM's WRITE state: pops configuration bytes from fifo1, shifts them MSB-first to the pixel chip on `sdo` under a generated `sclk`, and samples the chip's return line `sdi` on the same clock. Each returned byte is assembled and pushed into fifo2 for later UART transmission. The control FSM gates the engine with `run` and waits for `done`.

## Interface
Parameters:
- `CLK_DIV`, default 50: half-period of `sclk` in `clk_100` cycles. 50 gives 1 MHz. Legal range is ≥2.
- `ACK_TIMEOUT`, default 4: cycles to wait for `fifo1_valid` after a read strobe.

Ports:
- `clk_100`  in  1  system clock, 100 MHz
- `Reset`  in  1  synchronous, active-high
- `run`  in  1  level; engine may start bytes while high
- `fifo1_empty`  in  1  fifo1 empty flag
- `fifo1_dout`  in  8  fifo1 read data
- `fifo1_valid`  in  1  fifo1 read acknowledge; data valid this cycle
- `fifo1_rd_en`  out  1  one-cycle read strobe
- `fifo2_full`  in  1  fifo2 full flag
- `fifo2_din`  out  8  assembled return byte
- `fifo2_wr_en`  out  1  one-cycle write strobe
- `sclk`  out  1  chip shift clock
- `sdo`  out  1  serial data to chip
- `sdi`  in  1  serial data from chip, already synchronised
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when fifo1 drains or `run` falls
- `ack_err`  out  1  sticky; set on read-ack timeout
- `byte_count`  out  16  bytes completed since reset; wraps at 0xFFFF→0

## Operation
- Reset value of every output is 0.
- States:
  - IDLE: go to FETCH when `run & !fifo1_empty`.
  - FETCH: assert `fifo1_rd_en` for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: on `fifo1_valid`, latch `fifo1_dout` into the tx shift register, load bit counter 7, go to SHIFT. If no ack within `ACK_TIMEOUT` cycles, set `ack_err`, pulse `done`, go to IDLE.
  - SHIFT: 8 bit periods, each 2·`CLK_DIV` cycles.
    - `sdo` = tx[7] for the whole period.
    - `sclk` is low for the first `CLK_DIV` cycles and high for the second.
    - `sdi` is sampled into rx[0] (rx shifts left) on the cycle `sclk` goes high.
    - tx shifts left at the end of each period.
    - After bit 0's period, go to STORE with `sclk` = 0.
  - STORE: when `!fifo2_full`, drive `fifo2_din` = rx, pulse `fifo2_wr_en` once, and increment `byte_count`.
    - Next state is FETCH if `run & !fifo1_empty`.
    - Otherwise pulse `done` and go to IDLE.
- `sdo` returns to 0 in IDLE. `sclk` is 0 in every state except SHIFT's high phase.

## Timing
- Per-byte latency with zero-wait FIFO ack:
  - FETCH 1 + WAIT_ACK 1 + SHIFT 16·`CLK_DIV` + STORE 1 = 16·`CLK_DIV` + 3 cycles.
  - Back-to-back bytes need no IDLE cycle.
- `fifo1_rd_en` and `fifo2_wr_en` are never high for two consecutive cycles. At most one read is outstanding.
- Boundary rules:
  - `run` falls mid-byte: finish the current byte, store it, pulse `done`, go to IDLE. No new FETCH is issued.
  - `fifo2_full` in STORE: hold in STORE (`sclk` low, `sdo` held) until not full. No data is dropped. `byte_count` increments only on the write.
  - `fifo1_empty` at the FETCH decision: no read is issued; `done` pulses in the same cycle as the last `fifo2_wr_en`.
  - `Reset` at any cycle, including mid-SHIFT: next cycle is IDLE with all outputs 0. A partial byte is discarded and `ack_err` is cleared.
  - `run` high while fifo1 is empty in IDLE: stay in IDLE; no `done` pulse.

## Test plan
- `CLK_DIV`=4; fifo1 holds 0xA5; `sdi` loops back `sdo`; `run`=1.
  - Required: `sdo` sequence 1,0,1,0,0,1,0,1 with each bit 8 cycles wide.
  - Required: fifo2 receives 0xA5 67 cycles after `run`; `byte_count`=1; `done` pulses once.
- Three bytes 0x00, 0xFF, 0x3C with `sdi` tied 1.
  - Required: fifo2 receives 0xFF, 0xFF, 0xFF with no IDLE cycles between bytes; `byte_count`=3.
- `fifo2_full` held high for 20 cycles at STORE of byte 0x81.
  - Required: engine stalls and `sclk` stays 0; the write of 0x81 occurs the cycle after `full` falls.
- `run` deasserted during bit 3 of the first of two queued bytes.
  - Required: only one fifo2 write; `done` pulses; fifo1 still holds the second byte.
- `fifo1_valid` never asserted.
  - Required: `ack_err`=1 and `done` pulses 4 cycles after `fifo1_rd_en`.
  - Required: then `Reset` clears `ack_err` and `byte_count`.
- `Reset` asserted mid-SHIFT.
  - Required: next cycle `sclk`=`sdo`=`busy`=0; no fifo2 write follows.
